// File: rtl/ik_target_slew.sv
// Frame-synchronous target slew: shadow/target/cur coordinate triples, with cur
// stepping toward target by at most STEP once per frame through one shared stepper.
module ik_target_slew #(
    parameter int W    = 8,
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_valid,
    input  logic [1:0]   wr_axis,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    input  logic         frame_start,
    output logic [W-1:0] cur0,
    output logic [W-1:0] cur1,
    output logic [W-1:0] cur2,
    output logic         update,
    output logic         settled,
    output logic [7:0]   overrun
);

    typedef enum logic [2:0] {S_IDLE, S_STEP0, S_STEP1, S_STEP2, S_DONE} state_t;

    localparam logic signed [W:0] STEP_S = (W+1)'(STEP);
    localparam logic [W-1:0]      STEP_U = W'(STEP);

    state_t              state_q, state_d;
    logic [2:0][W-1:0]   shadow_q, shadow_d;
    logic [2:0][W-1:0]   target_q, target_d;
    logic [2:0][W-1:0]   cur_q, cur_d;
    logic                pending_q, pending_d;
    logic                update_q, update_d;
    logic                settled_q, settled_d;
    logic [7:0]          overrun_q, overrun_d;

    logic [1:0]          ax;
    logic [W-1:0]        s_cur, s_tgt, s_next;
    logic signed [W:0]   diff;

    // Shared stepper: the axis is chosen by the current STEPk state.
    always_comb begin
        ax = 2'd0;
        case (state_q)
            S_STEP1: ax = 2'd1;
            S_STEP2: ax = 2'd2;
            default: ax = 2'd0;
        endcase
        s_cur = cur_q[ax];
        s_tgt = target_q[ax];
        diff  = $signed({1'b0, s_tgt}) - $signed({1'b0, s_cur});
        if (diff > STEP_S)
            s_next = s_cur + STEP_U;
        else if (diff < -STEP_S)
            s_next = s_cur - STEP_U;
        else
            s_next = s_tgt;
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        target_d  = target_q;
        cur_d     = cur_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (wr_valid && wr_axis != 2'd3)
            shadow_d[wr_axis] = wr_data;

        if (frame_start && state_q != S_IDLE && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                // shadow_d so a write in the commit cycle is included
                if (commit)
                    target_d = shadow_d;
                if (frame_start)
                    state_d = S_STEP0;
            end
            S_STEP0: begin
                cur_d[0] = s_next;
                state_d  = S_STEP1;
            end
            S_STEP1: begin
                cur_d[1] = s_next;
                state_d  = S_STEP2;
            end
            S_STEP2: begin
                cur_d[2] = s_next;
                state_d  = S_DONE;
            end
            S_DONE: begin
                // A commit arriving in DONE itself is honoured on the same edge.
                if (pending_q || commit)
                    target_d = shadow_d;
                pending_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (commit && state_q != S_IDLE && state_q != S_DONE)
            pending_d = 1'b1;

        update_d  = (state_d == S_DONE);
        settled_d = (state_d == S_IDLE) && (cur_d == target_d) && !pending_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            target_q  <= '0;
            cur_q     <= '0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            settled_q <= 1'b1;
            overrun_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            target_q  <= target_d;
            cur_q     <= cur_d;
            pending_q <= pending_d;
            update_q  <= update_d;
            settled_q <= settled_d;
            overrun_q <= overrun_d;
        end
    end

    assign cur0    = cur_q[0];
    assign cur1    = cur_q[1];
    assign cur2    = cur_q[2];
    assign update  = update_q;
    assign settled = settled_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ik_target_slew.sv
// Bench for ik_target_slew: frame tasks push expected cur triples, a monitor pops
// and compares them on each update pulse; timing and status flags checked inline.
module tb_ik_target_slew;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_valid, commit, frame_start;
    logic [1:0] wr_axis;
    logic [7:0] wr_data;
    logic [7:0] cur0, cur1, cur2, overrun;
    logic       update, settled;
    logic [7:0] b_cur0, b_cur1, b_cur2, b_overrun;
    logic       b_update, b_settled;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        int c0;
        int c1;
        int c2;
    } exp_t;
    exp_t exp_q[$];

    ik_target_slew #(.W(8), .STEP(4)) dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_axis(wr_axis),
        .wr_data(wr_data), .commit(commit), .frame_start(frame_start),
        .cur0(cur0), .cur1(cur1), .cur2(cur2), .update(update),
        .settled(settled), .overrun(overrun)
    );

    ik_target_slew #(.W(8), .STEP(255)) u_big (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_axis(wr_axis),
        .wr_data(wr_data), .commit(commit), .frame_start(frame_start),
        .cur0(b_cur0), .cur1(b_cur1), .cur2(b_cur2), .update(b_update),
        .settled(b_settled), .overrun(b_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Monitor: every update pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && update) begin
            if (exp_q.size() == 0) begin
                ntot++;
                $display("FAIL unexpected_update: got update with cur=%0d,%0d,%0d, expected none",
                         cur0, cur1, cur2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_cur0", int'(cur0), e.c0);
                chk("sb_cur1", int'(cur1), e.c1);
                chk("sb_cur2", int'(cur2), e.c2);
            end
        end
    end

    // Called at a negedge (cycle t). cm / fs2: cycle offset for a commit /
    // second frame_start pulse, -1 for none. Returns at the middle of t+5.
    task automatic do_frame(input int e0, input int e1, input int e2,
                            input int cm, input int fs2);
        exp_q.push_back('{e0, e1, e2});
        frame_start = 1'b1;
        commit      = (cm == 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            frame_start = (c == fs2);
            commit      = (c == cm);
            chk($sformatf("update_t%0d", c), int'(update), (c == 4) ? 1 : 0);
        end
        frame_start = 1'b0;
        commit      = 1'b0;
    endtask

    task automatic wr(input int ax, input int d, input bit cm);
        wr_valid = 1'b1;
        wr_axis  = 2'(ax);
        wr_data  = 8'(d);
        commit   = cm;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset_n = 1'b0; wr_valid = 1'b0; commit = 1'b0; frame_start = 1'b0;
        wr_axis = 2'd0; wr_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cur0", int'(cur0), 0);
        chk("rst_settled", int'(settled), 1);
        chk("rst_update", int'(update), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic slew
        wr(0, 10, 0); wr(1, 3, 0); wr(2, 0, 0);
        chk("shadow_only_settled", int'(settled), 1);
        wr(0, 10, 1);
        chk("commit_unsettled", int'(settled), 0);
        do_frame(4, 3, 0, -1, -1);
        chk("f1_settled", int'(settled), 0);
        do_frame(8, 3, 0, -1, -1);
        chk("f2_settled", int'(settled), 0);
        do_frame(10, 3, 0, -1, -1);
        chk("f3_settled", int'(settled), 1);

        // ignored axis 3
        wr(3, 'hAA, 1);
        chk("ax3_settled_a", int'(settled), 1);
        @(negedge clk);
        chk("ax3_settled_b", int'(settled), 1);
        do_frame(10, 3, 0, -1, -1);
        chk("ax3_settled_c", int'(settled), 1);

        // write-through commit
        wr(1, 20, 1);
        chk("wt_unsettled", int'(settled), 0);
        do_frame(10, 7, 0, -1, -1);
        do_frame(10, 11, 0, -1, -1);
        do_frame(10, 15, 0, -1, -1);
        do_frame(10, 19, 0, -1, -1);
        do_frame(10, 20, 0, -1, -1);
        chk("wt_settled", int'(settled), 1);

        // deferred commit at t+2
        wr(0, 50, 0);
        chk("def_pre_settled", int'(settled), 1);
        do_frame(10, 20, 0, 2, -1);
        chk("def_t5_settled", int'(settled), 0);
        do_frame(14, 20, 0, -1, -1);

        // overrun: second pulse at t+2 dropped
        do_frame(18, 20, 0, -1, 2);
        chk("overrun_1", int'(overrun), 1);
        e0 = 18;
        for (int i = 0; i < 300; i++) begin
            e0 = (e0 + 4 > 50) ? 50 : e0 + 4;
            do_frame(e0, 20, 0, -1, 2);
        end
        chk("overrun_sat", int'(overrun), 255);

        // upward to 255, then downward to 0
        wr(0, 255, 1);
        e0 = 50;
        for (int i = 0; i < 52; i++) begin
            e0 = (e0 + 4 > 255) ? 255 : e0 + 4;
            do_frame(e0, 20, 0, -1, -1);
        end
        chk("top_cur0", int'(cur0), 255);
        chk("big_top_cur0", int'(b_cur0), 255);
        wr(0, 0, 1);
        do_frame(251, 20, 0, -1, -1);
        chk("big_jump_cur0", int'(b_cur0), 0);
        e0 = 251;
        for (int i = 0; i < 63; i++) begin
            e0 = (e0 > 4) ? e0 - 4 : 0;
            do_frame(e0, 20, 0, -1, -1);
        end
        chk("bottom_cur0", int'(cur0), 0);
        chk("bottom_settled", int'(settled), 1);

        // asynchronous reset in the middle of a step
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_cur0", int'(cur0), 0);
        chk("arst_cur1", int'(cur1), 0);
        chk("arst_cur2", int'(cur2), 0);
        chk("arst_settled", int'(settled), 1);
        chk("arst_overrun", int'(overrun), 0);
        chk("arst_update", int'(update), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_cur1", int'(cur1), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
